// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 SPI responder.
// Build option: SSD1306_VERTICAL_MODE_EN enables vertical addressing (mode 1).
package ssd1306_pkg;

  localparam int PAGE_W = 3;
  localparam int COL_W  = 7;

  typedef enum logic [1:0] {
    ADDR_HORIZ = 2'd0,
    ADDR_VERT  = 2'd1,
    ADDR_PAGE  = 2'd2
  } addr_mode_t;

  typedef enum logic [1:0] {
    ST_CMD  = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } cmd_state_t;

  localparam logic [7:0] CMD_MEM_MODE  = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_CONTRAST  = 8'h81;
  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
  localparam logic [7:0] CMD_NORMAL    = 8'hA6;
  localparam logic [7:0] CMD_INVERSE   = 8'hA7;

  function automatic logic takes_args(input logic [7:0] op);
    return (op == CMD_MEM_MODE) || (op == CMD_COL_ADDR) ||
           (op == CMD_PAGE_ADDR) || (op == CMD_CONTRAST);
  endfunction

  // Mode 3 is reserved on the panel and behaves like page addressing.
  function automatic addr_mode_t decode_mode(input logic [1:0] arg);
    case (arg)
      2'd0:    return ADDR_HORIZ;
`ifdef SSD1306_VERTICAL_MODE_EN
      2'd1:    return ADDR_VERT;
`else
      2'd1:    return ADDR_HORIZ;
`endif
      default: return ADDR_PAGE;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_spi_rx_byte.sv
// Oversampled SPI mode-0 byte receiver: pin synchronizers, sclk edge
// detect, MSB-first shift register and bit counter; pulses byte_valid.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_100m,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  // Bit order {dc, cs_n, mosi, sclk}; chip select idles deasserted.
  localparam logic [3:0] SYNC_RST = 4'b0100;

  logic [3:0] pins;
  logic [3:0] synced;

  assign pins = {spi_dc, spi_cs_n, spi_mosi, spi_sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
        else       chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
      end
      assign synced[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic       sclk_prev_reg;
  logic       cs_n_d_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       valid_reg;
  logic [7:0] data_reg;
  logic       dc_reg;
  logic       sclk_rise;
  logic       cs_active;
  logic [7:0] shift_next;

  assign sclk_rise  = synced[0] & ~sclk_prev_reg;
  // Accept a bit while cs_n was low now or last cycle so that cs_n rising
  // together with the final sclk edge still completes the byte.
  assign cs_active  = ~synced[2] | ~cs_n_d_reg;
  assign shift_next = {shift_reg[6:0], synced[1]};

  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) begin
      sclk_prev_reg <= 1'b0;
      cs_n_d_reg    <= 1'b1;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      valid_reg     <= 1'b0;
      data_reg      <= 8'h00;
      dc_reg        <= 1'b0;
    end else begin
      sclk_prev_reg <= synced[0];
      cs_n_d_reg    <= synced[2];
      valid_reg     <= 1'b0;
      if (sclk_rise && cs_active) begin
        shift_reg   <= shift_next;
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          valid_reg <= 1'b1;
          data_reg  <= shift_next;
          dc_reg    <= synced[3];
        end
      end else if (synced[2]) begin
        bit_cnt_reg <= 3'd0;
        shift_reg   <= 8'h00;
      end
    end
  end

  assign byte_valid = valid_reg;
  assign byte_data  = data_reg;
  assign byte_dc    = dc_reg;

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 command/data decoder: framebuffer writes, address pointers and
// panel settings. Build option: SSD1306_VERTICAL_MODE_EN (vertical mode).
module ssd1306_spi_rx
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FB_AW       = 10
) (
  input  logic             clk_100m,
  input  logic             reset,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  input  logic             spi_cs_n,
  input  logic             spi_dc,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_wdata,
  output logic             display_on,
  output logic             invert,
  output logic [7:0]       contrast
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clk_100m   (clk_100m),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_dc     (spi_dc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  cmd_state_t        state_reg, state_next;
  logic [7:0]        pend_cmd_reg;
  addr_mode_t        mode_reg;
  logic [COL_W-1:0]  col_reg, col_start_reg, col_end_reg;
  logic [PAGE_W-1:0] page_reg, page_start_reg, page_end_reg;
  logic              fb_we_reg;
  logic [FB_AW-1:0]  fb_addr_reg;
  logic [7:0]        fb_wdata_reg;
  logic              display_on_reg, invert_reg;
  logic [7:0]        contrast_reg;

  // Wrap is an equality test, so start > end runs through 127 -> 0 first.
  logic              col_at_end, page_at_end;
  logic [COL_W-1:0]  col_step;
  logic [PAGE_W-1:0] page_step;

  assign col_at_end  = (col_reg == col_end_reg);
  assign page_at_end = (page_reg == page_end_reg);
  assign col_step    = col_at_end  ? col_start_reg  : col_reg + 7'd1;
  assign page_step   = page_at_end ? page_start_reg : page_reg + 3'd1;

  always_comb begin
    state_next = state_reg;
    if (byte_valid && !byte_dc) begin
      case (state_reg)
        ST_CMD:  if (takes_args(byte_data)) state_next = ST_ARG1;
        ST_ARG1: state_next = (pend_cmd_reg == CMD_COL_ADDR || pend_cmd_reg == CMD_PAGE_ADDR)
                              ? ST_ARG2 : ST_CMD;
        default: state_next = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) state_reg <= ST_CMD;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) begin
      pend_cmd_reg   <= 8'h00;
      mode_reg       <= ADDR_PAGE;
      col_reg        <= '0;
      col_start_reg  <= '0;
      col_end_reg    <= 7'd127;
      page_reg       <= '0;
      page_start_reg <= '0;
      page_end_reg   <= 3'd7;
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      fb_wdata_reg   <= 8'h00;
      display_on_reg <= 1'b0;
      invert_reg     <= 1'b0;
      contrast_reg   <= 8'h7F;
    end else begin
      fb_we_reg <= 1'b0;
      if (byte_valid && byte_dc) begin
        fb_we_reg    <= 1'b1;
        fb_addr_reg  <= FB_AW'({page_reg, col_reg});
        fb_wdata_reg <= byte_data;
        case (mode_reg)
          ADDR_HORIZ: begin
            col_reg <= col_step;
            if (col_at_end) page_reg <= page_step;
          end
`ifdef SSD1306_VERTICAL_MODE_EN
          ADDR_VERT: begin
            page_reg <= page_step;
            if (page_at_end) col_reg <= col_step;
          end
`endif
          default: col_reg <= col_step;
        endcase
      end else if (byte_valid) begin
        case (state_reg)
          ST_CMD: begin
            if (takes_args(byte_data))          pend_cmd_reg  <= byte_data;
            if (byte_data[7:3] == 5'b10110)     page_reg      <= byte_data[2:0];
            if (byte_data[7:4] == 4'h0)         col_reg[3:0]  <= byte_data[3:0];
            if (byte_data[7:3] == 5'b00010)     col_reg[6:4]  <= byte_data[2:0];
            if (byte_data == CMD_DISP_OFF)      display_on_reg <= 1'b0;
            if (byte_data == CMD_DISP_ON)       display_on_reg <= 1'b1;
            if (byte_data == CMD_NORMAL)        invert_reg     <= 1'b0;
            if (byte_data == CMD_INVERSE)       invert_reg     <= 1'b1;
          end
          ST_ARG1: begin
            case (pend_cmd_reg)
              CMD_MEM_MODE: mode_reg <= decode_mode(byte_data[1:0]);
              CMD_COL_ADDR: begin
                col_start_reg <= byte_data[COL_W-1:0];
                col_reg       <= byte_data[COL_W-1:0];
              end
              CMD_PAGE_ADDR: begin
                page_start_reg <= byte_data[PAGE_W-1:0];
                page_reg       <= byte_data[PAGE_W-1:0];
              end
              CMD_CONTRAST: contrast_reg <= byte_data;
              default: ;
            endcase
          end
          default: begin
            if (pend_cmd_reg == CMD_COL_ADDR)  col_end_reg  <= byte_data[COL_W-1:0];
            if (pend_cmd_reg == CMD_PAGE_ADDR) page_end_reg <= byte_data[PAGE_W-1:0];
          end
        endcase
      end
    end
  end

  assign fb_we      = fb_we_reg;
  assign fb_addr    = fb_addr_reg;
  assign fb_wdata   = fb_wdata_reg;
  assign display_on = display_on_reg;
  assign invert     = invert_reg;
  assign contrast   = contrast_reg;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Randomized scoreboard bench for ssd1306_spi_rx against a byte-level model.
`timescale 1ns/1ps
module tb_ssd1306_spi_rx;

  localparam int SYNC_STAGES = 2;

  logic       clk_100m = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, spi_dc = 1'b0;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       display_on, invert;
  logic [7:0] contrast;

  ssd1306_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .FB_AW(10)) dut (
    .clk_100m   (clk_100m),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_dc     (spi_dc),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .display_on (display_on),
    .invert     (invert),
    .contrast   (contrast)
  );

  always #5 clk_100m = ~clk_100m;

  longint cyc = 0;
  always @(posedge clk_100m) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    longint     t;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: panel state as plain integers.
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_on, m_inv, m_con, m_pend, m_argi;

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_mode = 2; m_on = 0; m_inv = 0; m_con = 'h7F; m_pend = 0; m_argi = 0;
  endtask

  task automatic model_byte(input logic [7:0] b_in, input bit d, input longint t);
    exp_t e;
    int b, m;
    b = int'(b_in);
    if (d) begin
      e.addr = 10'(m_page * 128 + m_col);
      e.data = b_in;
      e.t = t;
      exp_q.push_back(e);
      $display("tx data %02h -> page %0d col %0d", b, m_page, m_col);
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          m_col = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
    end else if (m_pend != 0) begin
      $display("tx arg  %02h for cmd %02h", b, m_pend);
      case (m_pend)
        'h20: begin
          m = b % 4;
          if (m == 3) m = 2;
`ifndef SSD1306_VERTICAL_MODE_EN
          if (m == 1) m = 0;
`endif
          m_mode = m; m_pend = 0;
        end
        'h21: if (m_argi == 0) begin m_cs = b % 128; m_col = m_cs; m_argi = 1; end
              else begin m_ce = b % 128; m_pend = 0; end
        'h22: if (m_argi == 0) begin m_ps = b % 8; m_page = m_ps; m_argi = 1; end
              else begin m_pe = b % 8; m_pend = 0; end
        default: begin m_con = b; m_pend = 0; end
      endcase
    end else begin
      $display("tx cmd  %02h", b);
      if (b == 'h20 || b == 'h21 || b == 'h22 || b == 'h81) begin m_pend = b; m_argi = 0; end
      else if (b == 'hAE) m_on = 0;
      else if (b == 'hAF) m_on = 1;
      else if (b == 'hA6) m_inv = 0;
      else if (b == 'hA7) m_inv = 1;
      else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
      else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 'h10 && b <= 'h17) m_col = (m_col % 16) + (b - 'h10) * 16;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit d);
    longint t;
    if (spi_cs_n) begin
      spi_cs_n = 1'b0;
      repeat (2) @(posedge clk_100m);
    end
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk_100m); #1;
      spi_sclk = 1'b0; spi_mosi = b[i]; spi_dc = d;
      repeat ($urandom_range(2, 3)) @(posedge clk_100m);
      #1; spi_sclk = 1'b1; t = cyc;
      if (i == 0) model_byte(b, d, t);
      repeat ($urandom_range(1, 2)) @(posedge clk_100m);
    end
  endtask

  task automatic send_cmds(input logic [7:0] list[$]);
    foreach (list[k]) send_byte(list[k], 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk_100m);
      n++;
    end
    repeat (8) @(posedge clk_100m);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_settings(input string tag);
    @(negedge clk_100m);
    check({tag, "_display_on"}, 64'(display_on), 64'(m_on));
    check({tag, "_invert"}, 64'(invert), 64'(m_inv));
    check({tag, "_contrast"}, 64'(contrast), 64'(m_con));
  endtask

  // Monitor: each write strobe pops one expected write.
  always @(negedge clk_100m) begin
    exp_t e;
    if (!reset && fb_we) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", fb_addr, fb_wdata);
      end else begin
        e = exp_q.pop_front();
        $display("rx write addr %03h data %02h", fb_addr, fb_wdata);
        check("wr_addr", 64'(fb_addr), 64'(e.addr));
        check("wr_data", 64'(fb_wdata), 64'(e.data));
        check("wr_latency", 64'(cyc - e.t), 64'(SYNC_STAGES + 2));
      end
    end
  end

  initial begin
    logic [7:0] b;
    model_reset();
    repeat (5) @(posedge clk_100m);
    #1 reset = 1'b0;
    @(negedge clk_100m);
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_fb_addr", 64'(fb_addr), 64'd0);
    check("rst_fb_wdata", 64'(fb_wdata), 64'd0);
    check_settings("rst");

    send_cmds('{8'hAF, 8'hA7, 8'h81, 8'h40});
    drain();
    check_settings("cmds");
    check("cmds_contrast_40", 64'(contrast), 64'h40);

    send_cmds('{8'h20, 8'h00, 8'h21, 8'd0, 8'd127, 8'h22, 8'd0, 8'd7});
    for (int i = 0; i < 1025; i++) send_byte(8'(i), 1'b1);
    drain();

    send_cmds('{8'h20, 8'h02, 8'hB3, 8'h05, 8'h12});
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    drain();

    send_cmds('{8'h20, 8'h00, 8'h21, 8'd126, 8'd127, 8'h22, 8'd6, 8'd7});
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    drain();

    // Partial byte aborted by cs_n, then a clean data byte.
    spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_100m); #1; spi_sclk = 1'b0; spi_mosi = 1'($urandom); spi_dc = 1'b1;
      repeat (3) @(posedge clk_100m);
      #1; spi_sclk = 1'b1;
      repeat (2) @(posedge clk_100m);
    end
    #1; spi_sclk = 1'b0; spi_cs_n = 1'b1;
    repeat (6) @(posedge clk_100m);
    send_byte(8'hA5, 1'b1);
    drain();

    send_cmds('{8'h20, 8'h01, 8'h21, 8'd0, 8'd127, 8'h22, 8'd0, 8'd7});
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b1);
    drain();

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hAE;  1: b = 8'hAF;  2: b = 8'hA6;  3: b = 8'hA7;
        4: b = 8'h20;  5: b = 8'h21;  6: b = 8'h22;  7: b = 8'h81;
        8: b = 8'hB0 + 8'($urandom_range(0, 7));
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom), 1'b1);
      else send_byte(b, 1'b0);
    end
    drain();
    check_settings("rand");

    // Asynchronous reset in the middle of a data byte.
    send_cmds('{8'h20, 8'h02, 8'hAF, 8'h81, 8'h33});
    send_byte(8'h5A, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_100m); #1; spi_sclk = 1'b0; spi_mosi = 1'b1; spi_dc = 1'b1;
      repeat (3) @(posedge clk_100m);
      #1; spi_sclk = 1'b1;
      repeat (2) @(posedge clk_100m);
    end
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_display_on", 64'(display_on), 64'd0);
    check("async_rst_contrast", 64'(contrast), 64'h7F);
    check("async_rst_fb_addr", 64'(fb_addr), 64'd0);
    check("async_rst_fb_we", 64'(fb_we), 64'd0);
    spi_sclk = 1'b0; spi_cs_n = 1'b1;
    repeat (3) @(posedge clk_100m);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk_100m);
    send_cmds('{8'hAF});
    send_byte(8'hC3, 1'b1);
    drain();
    check_settings("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_rx.md
# ssd1306_spi_rx

SPI responder that receives the OLED display stream the Arduboy CPU core drives toward its SSD1306 controller, decodes the command/data protocol and writes display bytes into the framebuffer RAM read by the video generator. It runs entirely in the clk_100m domain. The external SPI pins are oversampled, so no SPI-clock domain exists. Outputs feed the framebuffer write port and the video pixel path (on/off, invert, contrast).

## Interface
Parameters:
- SYNC_STAGES, 2 — synchronizer depth on sclk/mosi/cs_n/dc (minimum 2).
- FB_AW, 10 — framebuffer address width: 8 pages × 128 columns.

Ports:
- clk_100m  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- spi_sclk  in  1  SPI clock from CPU core, mode 0, max 8 MHz.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs_n  in  1  chip select, active low.
- spi_dc  in  1  1 = data byte, 0 = command byte.
- fb_we  out  1  one-cycle framebuffer write strobe.
- fb_addr  out  FB_AW  write address {page[2:0], col[6:0]}.
- fb_wdata  out  8  byte to write; bit0 = top row of the page.
- display_on  out  1  panel enabled (0xAF) / blanked (0xAE).
- invert  out  1  inverse video (0xA7) / normal (0xA6).
- contrast  out  8  last value written by 0x81.

## Operation
- Inputs pass through SYNC_STAGES flops. An edge detector marks synced sclk 0→1. On that edge, with cs_n low, mosi shifts into an 8-bit register and a 3-bit counter increments.
- On the 8th bit the byte completes. dc is sampled with that bit. The counter returns to 0.
- cs_n high clears the bit counter and the partial byte. Command/argument state, pointers and settings are retained.
- Data byte (dc=1): fb_we=1, fb_addr={page,col}, fb_wdata=byte; then the pointer advances per addressing mode.
  - Horizontal (0): col++. At col_end, col←col_start and page++. At page_end, page←page_start.
  - Vertical (1): page++. At page_end, page←page_start and col++. At col_end, col←col_start.
  - Page (2, reset default): col++. At col_end, col←col_start. page is unchanged.
- Command FSM, states CMD, ARG1, ARG2. Only command bytes (dc=0) advance it. A data byte received in ARG1/ARG2 is written normally and does not change FSM state.
  - CMD, 0x20 → ARG1; the argument's low 2 bits set the mode (value 3 is treated as page).
  - CMD, 0x21 → ARG1 (col_start; col←col_start) → ARG2 (col_end) → CMD.
  - CMD, 0x22 → ARG1 (page_start; page←page_start) → ARG2 (page_end) → CMD. Arguments are masked to 3 bits.
  - CMD, 0x81 → ARG1 (contrast) → CMD.
  - CMD, 0xB0–0xB7 sets page←low 3 bits. 0x00–0x0F sets col[3:0]. 0x10–0x17 sets col[6:4].
  - CMD, 0xAE/0xAF/0xA6/0xA7 update display_on/invert.
  - Any other command byte is ignored and stays in CMD.
- Column arguments are masked to 7 bits. If start > end, the wrap compares equality with end only (the pointer runs to 127 → 0 before reaching end).

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_wdata=0, display_on=0, invert=0, contrast=0x7F, col=0, page=0, col range 0..127, page range 0..7, mode=page, FSM=CMD, bit counter=0.
- fb_we rises exactly SYNC_STAGES+2 clk_100m cycles after the 8th sclk rising edge at the pins, and lasts 1 cycle. Setting outputs update on that same cycle.
- Back-to-back bytes need no gap. At 8 MHz SCLK each phase is ≥6 cycles, so no edge is lost.
- cs_n rising in the same synced cycle as the 8th sclk edge: the byte completes, then the counter clears.
- reset asserted mid-byte: outputs go to reset values immediately (asynchronously). No write is issued.

## Configuration
- SSD1306_VERTICAL_MODE_EN defined: vertical addressing (mode 1) is implemented as above.
- SSD1306_VERTICAL_MODE_EN undefined: mode value 1 is treated as horizontal, and the vertical advance logic is not built.

## Structure
- ssd1306_pkg: addressing-mode enum (ADDR_HORIZ, ADDR_VERT, ADDR_PAGE), command opcode constants, FSM state enum, and the page/column width constants.
- Sub-module spi_byte_rx: synchronizers, edge detect, shift register and bit counter. It outputs a byte_valid pulse with byte and dc. ssd1306_spi_rx holds the FSM, pointers and settings.

## Test plan
- Reset, then 0xAF, 0xA7, 0x81, 0x40 as commands → display_on=1, invert=1, contrast=0x40, no fb_we.
- 0x20,0x00, 0x21,0,127, 0x22,0,7, then 1024 data bytes 0x00..0xFF repeating → addresses 0..1023 written in order, and the 1025th write goes to address 0.
- Page mode, 0xB3, 0x05, 0x12 (col=0x25), then 3 data bytes → fb_addr = 0x1A5, 0x1A6, 0x1A7.
- Horizontal, 0x21,126,127, 0x22,6,7, then 5 data bytes → col/page sequence (126,6),(127,6),(126,7),(127,7),(126,6).
- cs_n pulsed high after 5 bits, then a full data byte 0xA5 → single write of 0xA5 and no corruption.
- With SSD1306_VERTICAL_MODE_EN: 0x20,0x01, full range, then 9 data bytes → the 9th write goes to page 0, col 1.
